// File: rtl/alu_accum_seq.sv
// alu_accum_seq
//   Accumulate engine driven by the switch-code control decoder. Every rising
//   edge of the (synchronised) enable level executes exactly one operation on
//   an 8-bit accumulator: ADD (with carry-out) or XOR of the 4-bit code.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ctrl_rst     clear request level (highest priority)
//   ctrl_enable  operation trigger level; one op per rising edge
//   ctrl_arith   1 = ADD, 0 = XOR
//   operand      4-bit code {d,c,b,a}
//   acc_out      accumulator value
//   carry        carry-out of the last ADD; 0 after XOR or clear
//   op_done      one-clock strobe when an operation commits
//   op_count     committed operations since clear, saturating at 255
//   state_dbg    FSM state (IDLE=00, EXEC=01, HOLD=10, CLEAR=11)
//
// Handshake: op_done is a push-only strobe with no back-pressure. In the cycle
// it is high, acc_out, carry and op_count already hold the committed result.
module alu_accum_seq #(
   parameter int DATA_W      = 8,
   parameter int OP_W        = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ctrl_rst,
   input  logic              ctrl_enable,
   input  logic              ctrl_arith,
   input  logic [OP_W-1:0]   operand,
   output logic [DATA_W-1:0] acc_out,
   output logic              carry,
   output logic              op_done,
   output logic [7:0]        op_count,
   output logic [1:0]        state_dbg
);

   localparam int IN_W = OP_W + 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      EXEC  = 2'b01,
      HOLD  = 2'b10,
      CLEAR = 2'b11
   } state_t;

   state_t state, state_nxt;

   // All switch inputs share one synchroniser chain so they stay aligned.
   logic [IN_W-1:0] sync_q [SYNC_STAGES];
   logic            rst_s, en_s, arith_s;
   logic [OP_W-1:0] operand_s;
   logic            en_s_d;
   logic            en_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {ctrl_rst, ctrl_enable, ctrl_arith, operand};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign {rst_s, en_s, arith_s, operand_s} = sync_q[SYNC_STAGES-1];

   // Edge flop is updated in every state, so an enable that is still high
   // when a clear is released never looks like a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_s_d <= 1'b0;
      else        en_s_d <= en_s;
   end

   assign en_rise = en_s & ~en_s_d;

   // FSM
   logic latch_op;
   logic commit;
   logic clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_op  = 1'b0;
      commit    = 1'b0;
      clear     = 1'b0;
      case (state)
         IDLE: begin
            if (en_rise) begin
               state_nxt = EXEC;
               latch_op  = 1'b1;
            end
         end
         EXEC: begin
            commit    = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (!en_s) state_nxt = IDLE;
         end
         CLEAR: begin
            if (!rst_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Clear overrides everything, including an op sitting in EXEC.
      if (rst_s) begin
         state_nxt = CLEAR;
         latch_op  = 1'b0;
         commit    = 1'b0;
         clear     = 1'b1;
      end
   end

   assign state_dbg = state;

   // Datapath
   logic [OP_W-1:0] op_q;
   logic            arith_q;
   logic [DATA_W:0] sum;

   assign sum = {1'b0, acc_out} + (DATA_W+1)'(op_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         arith_q <= 1'b0;
      end else if (latch_op) begin
         op_q    <= operand_s;
         arith_q <= arith_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_out  <= '0;
         carry    <= 1'b0;
         op_done  <= 1'b0;
         op_count <= '0;
      end else if (clear) begin
         acc_out  <= '0;
         carry    <= 1'b0;
         op_done  <= 1'b0;
         op_count <= '0;
      end else begin
         op_done <= commit;
         if (commit) begin
            if (arith_q) begin
               acc_out <= sum[DATA_W-1:0];
               carry   <= sum[DATA_W];
            end else begin
               acc_out <= acc_out ^ DATA_W'(op_q);
               carry   <= 1'b0;
            end
            if (op_count != 8'hFF) op_count <= op_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_accum_seq.sv
module tb_alu_accum_seq;

   logic       clk;
   logic       rst_n;
   logic       ctrl_rst;
   logic       ctrl_enable;
   logic       ctrl_arith;
   logic [3:0] operand;
   logic [7:0] acc_out;
   logic       carry;
   logic       op_done;
   logic [7:0] op_count;
   logic [1:0] state_dbg;

   alu_accum_seq #(.DATA_W(8), .OP_W(4), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ctrl_rst    (ctrl_rst),
      .ctrl_enable (ctrl_enable),
      .ctrl_arith  (ctrl_arith),
      .operand     (operand),
      .acc_out     (acc_out),
      .carry       (carry),
      .op_done     (op_done),
      .op_count    (op_count),
      .state_dbg   (state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int total = 0;
   int bad   = 0;

   // scoreboard: expected {acc, carry, count} and expected op_done edge
   logic [16:0] exp_q[$];
   int          lat_q[$];

   // reference model state
   int m_acc   = 0;
   int m_carry = 0;
   int m_cnt   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_acc   = 0;
      m_carry = 0;
      m_cnt   = 0;
   endfunction

   function automatic void model_op(input logic ar, input logic [3:0] op);
      int s;
      if (ar) begin
         s       = m_acc + int'(op);
         m_carry = (s > 255) ? 1 : 0;
         m_acc   = s % 256;
      end else begin
         m_acc   = m_acc ^ int'(op);
         m_carry = 0;
      end
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      exp_q.push_back({m_acc[7:0], m_carry[0], m_cnt[7:0]});
   endfunction

   // monitor
   always @(negedge clk) begin
      if (rst_n && op_done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_op_done: got op_done=1 expected none (t=%0t)", $time);
         end else begin
            logic [16:0] e;
            int          l;
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            chk("sb_acc",   {24'd0, acc_out},  {24'd0, e[16:9]});
            chk("sb_carry", {31'd0, carry},    {31'd0, e[8]});
            chk("sb_count", {24'd0, op_count}, {24'd0, e[7:0]});
            chk("sb_latency_edge", edge_cnt, l);
         end
      end
   end

   // driver tasks
   task automatic press(input logic ar, input logic [3:0] op, input int hold, input bit scramble);
      @(negedge clk);
      operand    = op;
      ctrl_arith = ar;
      @(negedge clk);
      ctrl_enable = 1'b1;
      model_op(ar, op);
      lat_q.push_back(edge_cnt + 4);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (scramble && i == 3) begin
            operand    = 4'($urandom);
            ctrl_arith = 1'($urandom);
         end
      end
      ctrl_enable = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      ctrl_rst = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      chk("clr_state", {30'd0, state_dbg}, 32'd3);
      chk("clr_acc",   {24'd0, acc_out},   32'd0);
      chk("clr_count", {24'd0, op_count},  32'd0);
      ctrl_rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   int saved_acc;

   initial begin
      rst_n       = 1'b0;
      ctrl_rst    = 1'b0;
      ctrl_enable = 1'b0;
      ctrl_arith  = 1'b0;
      operand     = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_acc",     {24'd0, acc_out},   32'd0);
      chk("rst_op_done", {31'd0, op_done},   32'd0);
      rst_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_state", {30'd0, state_dbg}, 32'd0);
         chk("idle_acc_carry_count", {15'd0, acc_out, carry, op_count}, 32'd0);
      end

      // three ADD 5 presses
      for (int k = 1; k <= 3; k++) begin
         press(1'b1, 4'h5, 3, 1'b0);
         chk("add5_acc", {24'd0, acc_out}, 32'(5 * k));
      end
      chk("add5_count", {24'd0, op_count}, 32'd3);

      // wrap: bring acc to FE, add 3, then XOR F
      do_clear();
      for (int k = 0; k < 16; k++) press(1'b1, 4'hF, 2, 1'b0);
      press(1'b1, 4'hE, 2, 1'b0);
      chk("fe_acc", {24'd0, acc_out}, 32'hFE);
      press(1'b1, 4'h3, 2, 1'b0);
      chk("wrap_acc",   {24'd0, acc_out}, 32'h01);
      chk("wrap_carry", {31'd0, carry},   32'd1);
      press(1'b0, 4'hF, 2, 1'b0);
      chk("xor_acc",   {24'd0, acc_out}, 32'h0E);
      chk("xor_carry", {31'd0, carry},   32'd0);

      // enable held for 100 clocks: single op
      @(negedge clk);
      operand    = 4'h1;
      ctrl_arith = 1'b1;
      @(negedge clk);
      ctrl_enable = 1'b1;
      model_op(1'b1, 4'h1);
      lat_q.push_back(edge_cnt + 4);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 50) chk("held_state_hold", {30'd0, state_dbg}, 32'd2);
      end
      ctrl_enable = 1'b0;
      repeat (6) @(negedge clk);
      chk("held_state_idle", {30'd0, state_dbg}, 32'd0);
      chk("held_acc", {24'd0, acc_out}, 32'h0F);

      // clear arriving while the op is in EXEC
      @(negedge clk);
      operand    = 4'h2;
      ctrl_arith = 1'b1;
      @(negedge clk);
      ctrl_enable = 1'b1;
      @(negedge clk);
      ctrl_rst = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      chk("rstexec_state", {30'd0, state_dbg}, 32'd3);
      chk("rstexec_acc",   {24'd0, acc_out},   32'd0);
      chk("rstexec_count", {24'd0, op_count},  32'd0);
      chk("rstexec_carry", {31'd0, carry},     32'd0);
      ctrl_rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("rel_en_high_state", {30'd0, state_dbg}, 32'd0);
      chk("rel_en_high_acc",   {24'd0, acc_out},   32'd0);
      chk("rel_en_high_count", {24'd0, op_count},  32'd0);
      ctrl_enable = 1'b0;
      repeat (6) @(negedge clk);
      press(1'b1, 4'h2, 3, 1'b0);
      chk("after_clr_acc",   {24'd0, acc_out},  32'd2);
      chk("after_clr_count", {24'd0, op_count}, 32'd1);

      // rst_n asserted mid-operation
      @(negedge clk);
      operand    = 4'h7;
      ctrl_arith = 1'b1;
      @(negedge clk);
      ctrl_enable = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_acc",   {24'd0, acc_out},   32'd0);
      chk("async_rst_state", {30'd0, state_dbg}, 32'd0);
      chk("async_rst_count", {24'd0, op_count},  32'd0);
      chk("async_rst_done",  {31'd0, op_done},   32'd0);
      ctrl_enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // randomized operations, inputs scrambled after the latch point
      for (int k = 0; k < 40; k++) begin
         press(1'($urandom), 4'($urandom), $urandom_range(2, 8), 1'b1);
      end
      chk("rand_acc", {24'd0, acc_out}, 32'(m_acc));

      // saturation of the op counter
      saved_acc = m_acc;
      for (int k = 0; k < 257; k++) press(1'b1, 4'h0, 2, 1'b0);
      chk("sat_count", {24'd0, op_count}, 32'd255);
      chk("sat_acc",   {24'd0, acc_out},  32'(saved_acc));
      chk("sat_carry", {31'd0, carry},    32'd0);

      repeat (10) @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
